csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_if.sv | 19 +
 rtl/csr_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_csr_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_if.sv
// CSR access bus between the pipeline (master) and the machine-mode CSR unit (slave).
// Read data and the illegal flag are combinational on the address/op of the same cycle.
interface csr_if;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (
        output csr_addr, csr_op, csr_wdata,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_addr, csr_op, csr_wdata,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file with trap/interrupt/MRET sequencing and direct/vectored trap targets.
// Optional macro CSR_COUNTERS_EN adds the mcycle/minstret counters (CNT_W bits, 32..64).
module csr_unit #(
    parameter int unsigned HART_ID   = 0,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter int          CNT_W     = 64
) (
    input  logic        clk,
    input  logic        rst,
    csr_if.slave        bus,
    input  logic        trap_en,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic        mret_en,
    input  logic        instret,
    input  logic        irq_sw,
    input  logic        irq_tmr,
    input  logic        irq_ext,
    input  logic        irq_take,
    input  logic [31:0] irq_pc,
    output logic        irq_req,
    output logic [31:0] trap_target,
    output logic [31:0] mepc_out
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    logic        mstatus_mie_r;
    logic        mstatus_mpie_r;
    logic [2:0]  mie_r;            // {ext, tmr, sw}
    logic [29:0] mtvec_base_r;
    logic        mtvec_vec_r;      // 1 = vectored; modes 10/11 collapse to direct
    logic [31:0] mscratch_r;
    logic [29:0] mepc_r;
    logic [31:0] mcause_r;

    logic [2:0]  mip_s;
    logic [2:0]  pend_s;
    logic        irq_req_s;
    logic [4:0]  code_s;
    logic [31:0] irq_cause_s;
    logic [31:0] base_s;
    logic [31:0] trap_target_s;
    logic [31:0] mstatus_rd_s;
    logic [31:0] mie_rd_s;
    logic [31:0] mip_rd_s;
    logic [31:0] mtvec_rd_s;
    logic [31:0] rdata_s;
    logic        hit_s;
    logic        ro_s;
    logic        illegal_s;
    logic [31:0] wval_s;
    logic        take_s;
    logic        wr_en_s;
    logic        unused_s;

    assign mip_s        = {irq_ext, irq_tmr, irq_sw};
    assign mstatus_rd_s = {19'h0, 2'b11, 3'b000, mstatus_mpie_r, 3'b000, mstatus_mie_r, 3'b000};
    assign mie_rd_s     = {20'h0, mie_r[2], 3'b000, mie_r[1], 3'b000, mie_r[0], 3'b000};
    assign mip_rd_s     = {20'h0, mip_s[2], 3'b000, mip_s[1], 3'b000, mip_s[0], 3'b000};
    assign mtvec_rd_s   = {mtvec_base_r, 1'b0, mtvec_vec_r};

`ifdef CSR_COUNTERS_EN
    logic [CNT_W-1:0] mcycle_r;
    logic [CNT_W-1:0] minstret_r;
    logic [63:0]      mcycle_ext_s;
    logic [63:0]      minstret_ext_s;

    assign mcycle_ext_s   = 64'(mcycle_r);
    assign minstret_ext_s = 64'(minstret_r);
    assign unused_s       = ^{irq_pc[1:0], trap_pc[1:0]};
`else
    assign unused_s       = ^{instret, irq_pc[1:0], trap_pc[1:0], 32'(CNT_W)};
`endif

    // Pending interrupt selection (ext > sw > tmr) and trap handler address.
    always_comb begin
        pend_s    = mie_r & mip_s;
        irq_req_s = mstatus_mie_r & (|pend_s);
        code_s    = 5'd0;
        if (pend_s[2]) begin
            code_s = 5'd11;
        end else if (pend_s[0]) begin
            code_s = 5'd3;
        end else if (pend_s[1]) begin
            code_s = 5'd7;
        end else begin
            code_s = 5'd0;
        end
        irq_cause_s = {1'b1, 26'h0, code_s};
        base_s      = {mtvec_base_r, 2'b00};
        if (mtvec_vec_r && irq_req_s) begin
            trap_target_s = base_s + {25'h0, code_s, 2'b00};
        end else begin
            trap_target_s = base_s;
        end
    end

    // Address decode: read mux, implemented/read-only classification.
    always_comb begin
        rdata_s = 32'h0;
        hit_s   = 1'b1;
        ro_s    = 1'b0;
        case (bus.csr_addr)
            ADDR_MSTATUS:  rdata_s = mstatus_rd_s;
            ADDR_MIE:      rdata_s = mie_rd_s;
            ADDR_MTVEC:    rdata_s = mtvec_rd_s;
            ADDR_MSCRATCH: rdata_s = mscratch_r;
            ADDR_MEPC:     rdata_s = {mepc_r, 2'b00};
            ADDR_MCAUSE:   rdata_s = mcause_r;
            ADDR_MIP: begin
                rdata_s = mip_rd_s;
                ro_s    = 1'b1;
            end
            ADDR_MHARTID: begin
                rdata_s = 32'(HART_ID);
                ro_s    = 1'b1;
            end
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:    rdata_s = mcycle_ext_s[31:0];
            ADDR_MCYCLEH:   rdata_s = mcycle_ext_s[63:32];
            ADDR_MINSTRET:  rdata_s = minstret_ext_s[31:0];
            ADDR_MINSTRETH: rdata_s = minstret_ext_s[63:32];
`endif
            default: begin
                rdata_s = 32'h0;
                hit_s   = 1'b0;
            end
        endcase
    end

    // Write value formation and event arbitration; CSR writes lose to every commit event.
    always_comb begin
        case (bus.csr_op)
            2'b01:   wval_s = bus.csr_wdata;
            2'b10:   wval_s = rdata_s | bus.csr_wdata;
            2'b11:   wval_s = rdata_s & ~bus.csr_wdata;
            default: wval_s = rdata_s;
        endcase
        illegal_s = (bus.csr_op != 2'b00) && (!hit_s || ro_s);
        take_s    = irq_take & irq_req_s;
        wr_en_s   = (bus.csr_op != 2'b00) && !illegal_s && !trap_en && !take_s && !mret_en;
    end

    // Architectural CSR state update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
            mie_r          <= 3'b000;
            mtvec_base_r   <= MTVEC_RST[31:2];
            mtvec_vec_r    <= (MTVEC_RST[1:0] == 2'b01);
            mscratch_r     <= 32'h0;
            mepc_r         <= 30'h0;
            mcause_r       <= 32'h0;
        end else if (trap_en) begin
            mepc_r         <= trap_pc[31:2];
            mcause_r       <= trap_cause;
            mstatus_mpie_r <= mstatus_mie_r;
            mstatus_mie_r  <= 1'b0;
        end else if (take_s) begin
            mepc_r         <= irq_pc[31:2];
            mcause_r       <= irq_cause_s;
            mstatus_mpie_r <= mstatus_mie_r;
            mstatus_mie_r  <= 1'b0;
        end else if (mret_en) begin
            mstatus_mie_r  <= mstatus_mpie_r;
            mstatus_mpie_r <= 1'b1;
        end else if (wr_en_s) begin
            case (bus.csr_addr)
                ADDR_MSTATUS: begin
                    mstatus_mie_r  <= wval_s[3];
                    mstatus_mpie_r <= wval_s[7];
                end
                ADDR_MIE:      mie_r <= {wval_s[11], wval_s[7], wval_s[3]};
                ADDR_MTVEC: begin
                    mtvec_base_r <= wval_s[31:2];
                    mtvec_vec_r  <= (wval_s[1:0] == 2'b01);
                end
                ADDR_MSCRATCH: mscratch_r <= wval_s;
                ADDR_MEPC:     mepc_r     <= wval_s[31:2];
                ADDR_MCAUSE:   mcause_r   <= wval_s;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    // Free-running cycle and retired-instruction counters; a CSR write replaces that cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_r   <= '0;
            minstret_r <= '0;
        end else begin
            if (wr_en_s && (bus.csr_addr == ADDR_MCYCLE)) begin
                mcycle_r <= CNT_W'({mcycle_ext_s[63:32], wval_s});
            end else if (wr_en_s && (bus.csr_addr == ADDR_MCYCLEH)) begin
                mcycle_r <= CNT_W'({wval_s, mcycle_ext_s[31:0]});
            end else begin
                mcycle_r <= mcycle_r + CNT_W'(1);
            end
            if (wr_en_s && (bus.csr_addr == ADDR_MINSTRET)) begin
                minstret_r <= CNT_W'({minstret_ext_s[63:32], wval_s});
            end else if (wr_en_s && (bus.csr_addr == ADDR_MINSTRETH)) begin
                minstret_r <= CNT_W'({wval_s, minstret_ext_s[31:0]});
            end else if (instret) begin
                minstret_r <= minstret_r + CNT_W'(1);
            end else begin
                minstret_r <= minstret_r;
            end
        end
    end
`endif

    assign bus.csr_rdata   = rdata_s;
    assign bus.csr_illegal = illegal_s;
    assign irq_req         = irq_req_s;
    assign trap_target     = trap_target_s;
    assign mepc_out        = {mepc_r, 2'b00};

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: stimulus queues expected outputs, a negedge monitor compares them.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_en = 1'b0;
    logic [31:0] trap_pc = 32'h0;
    logic [31:0] trap_cause = 32'h0;
    logic        mret_en = 1'b0;
    logic        instret = 1'b0;
    logic        irq_sw = 1'b0;
    logic        irq_tmr = 1'b0;
    logic        irq_ext = 1'b0;
    logic        irq_take = 1'b0;
    logic [31:0] irq_pc = 32'h0;
    logic        irq_req;
    logic [31:0] trap_target;
    logic [31:0] mepc_out;

    csr_if bus_if ();

    csr_unit #(
        .HART_ID   (2),
        .MTVEC_RST (32'h0000_0100),
        .CNT_W     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .trap_en     (trap_en),
        .trap_pc     (trap_pc),
        .trap_cause  (trap_cause),
        .mret_en     (mret_en),
        .instret     (instret),
        .irq_sw      (irq_sw),
        .irq_tmr     (irq_tmr),
        .irq_ext     (irq_ext),
        .irq_take    (irq_take),
        .irq_pc      (irq_pc),
        .irq_req     (irq_req),
        .trap_target (trap_target),
        .mepc_out    (mepc_out)
    );

    always #5 clk = ~clk;

    // sel: 0 rdata, 1 illegal, 2 irq_req, 3 trap_target, 4 mepc_out
    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t        sb_q[$];
    chk_t        mon_c;
    logic [31:0] mon_act;
    int          checks = 0;
    int          failures = 0;

    // Monitor: compare every queued expectation against the settled outputs.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            mon_c = sb_q.pop_front();
            case (mon_c.sel)
                0:       mon_act = bus_if.csr_rdata;
                1:       mon_act = {31'h0, bus_if.csr_illegal};
                2:       mon_act = {31'h0, irq_req};
                3:       mon_act = trap_target;
                4:       mon_act = mepc_out;
                default: mon_act = 32'hDEAD_BEEF;
            endcase
            checks++;
            if (mon_act !== mon_c.exp) begin
                failures++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", mon_c.name, mon_act, mon_c.exp);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [31:0] exp, input string name);
        chk_t c;
        c.sel  = sel;
        c.exp  = exp;
        c.name = name;
        sb_q.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e, input string n);
        bus_if.csr_addr = a;
        bus_if.csr_op   = 2'b00;
        expect_val(0, e, n);
        step();
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d,
                      input logic ill, input string n);
        bus_if.csr_addr  = a;
        bus_if.csr_op    = op;
        bus_if.csr_wdata = d;
        expect_val(1, {31'h0, ill}, n);
        step();
        bus_if.csr_op = 2'b00;
    endtask

    initial begin
        bus_if.csr_addr  = 12'h000;
        bus_if.csr_op    = 2'b00;
        bus_if.csr_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        rd(12'h305, 32'h0000_0100, "rst_mtvec");
        rd(12'hF14, 32'h0000_0002, "hartid");
        expect_val(2, 32'h0, "rst_irq_req");
        expect_val(4, 32'h0, "rst_mepc_out");
        expect_val(3, 32'h0000_0100, "rst_trap_target");
        rd(12'h300, 32'h0000_1800, "rst_mstatus");
        rd(12'h342, 32'h0, "rst_mcause");
        rd(12'h304, 32'h0, "rst_mie");

        // Illegal accesses
        wr(12'hF14, 2'b01, 32'h5, 1'b1, "ill_hartid_wr");
        rd(12'hF14, 32'h0000_0002, "hartid_kept");
        expect_val(1, 32'h0, "unimpl_noop_legal");
        rd(12'h123, 32'h0, "unimpl_rd_zero");
        wr(12'h123, 2'b01, 32'h1, 1'b1, "ill_unimpl_wr");
        wr(12'h344, 2'b10, 32'h8, 1'b1, "ill_mip_set");

        // Write / set / clear on mscratch
        wr(12'h340, 2'b01, 32'h5A5A_A5A5, 1'b0, "scratch_wr_legal");
        rd(12'h340, 32'h5A5A_A5A5, "scratch_wr");
        wr(12'h340, 2'b10, 32'h0000_FFFF, 1'b0, "scratch_set_legal");
        rd(12'h340, 32'h5A5A_FFFF, "scratch_set");
        wr(12'h340, 2'b11, 32'h0F0F_0000, 1'b0, "scratch_clr_legal");
        rd(12'h340, 32'h5050_FFFF, "scratch_clr");

        // Timer interrupt taken
        wr(12'h300, 2'b01, 32'h8, 1'b0, "mstatus_wr");
        wr(12'h304, 2'b10, 32'h80, 1'b0, "mie_set");
        irq_tmr = 1'b1;
        expect_val(2, 32'h1, "tmr_irq_req");
        expect_val(3, 32'h0000_0100, "tmr_target_direct");
        rd(12'h344, 32'h0000_0080, "mip_tmr");
        irq_take = 1'b1;
        irq_pc   = 32'h40;
        step();
        irq_take = 1'b0;
        expect_val(4, 32'h40, "take_mepc");
        expect_val(2, 32'h0, "take_irq_off");
        rd(12'h342, 32'h8000_0007, "take_mcause");
        rd(12'h300, 32'h0000_1880, "take_mstatus");
        irq_take = 1'b1;
        irq_pc   = 32'h80;
        step();
        irq_take = 1'b0;
        expect_val(4, 32'h40, "take_ignored");

        // MRET restores MIE
        mret_en = 1'b1;
        step();
        mret_en = 1'b0;
        expect_val(2, 32'h1, "mret_irq_req");
        rd(12'h300, 32'h0000_1888, "mret_mstatus");

        // Vectored mode and priority
        wr(12'h305, 2'b01, 32'h201, 1'b0, "mtvec_wr");
        wr(12'h304, 2'b01, 32'h880, 1'b0, "mie_wr");
        irq_ext = 1'b1;
        expect_val(3, 32'h0000_022C, "vec_ext_target");
        expect_val(2, 32'h1, "vec_irq_req");
        rd(12'h305, 32'h0000_0201, "mtvec_vec_rd");
        wr(12'h300, 2'b11, 32'h8, 1'b0, "mie_clr");
        expect_val(2, 32'h0, "mie0_irq_req");
        expect_val(3, 32'h0000_0200, "mie0_target");
        rd(12'h300, 32'h0000_1880, "mie0_mstatus");
        wr(12'h300, 2'b10, 32'h8, 1'b0, "mie_set_again");
        wr(12'h304, 2'b01, 32'h888, 1'b0, "mie_all");
        irq_ext = 1'b0;
        irq_sw  = 1'b1;
        expect_val(3, 32'h0000_020C, "vec_sw_over_tmr");
        rd(12'h344, 32'h0000_0088, "mip_sw_tmr");
        irq_ext = 1'b1;
        expect_val(3, 32'h0000_022C, "vec_ext_over_sw");
        irq_take = 1'b1;
        irq_pc   = 32'h124;
        step();
        irq_take = 1'b0;
        irq_ext  = 1'b0;
        irq_sw   = 1'b0;
        irq_tmr  = 1'b0;
        expect_val(4, 32'h124, "ext_mepc");
        rd(12'h342, 32'h8000_000B, "ext_mcause");
        wr(12'h341, 2'b01, 32'h2003, 1'b0, "mepc_wr");
        expect_val(4, 32'h2000, "mepc_align_out");
        rd(12'h341, 32'h0000_2000, "mepc_align");
        wr(12'h305, 2'b01, 32'h302, 1'b0, "mtvec_mode10_wr");
        rd(12'h305, 32'h0000_0300, "mtvec_mode10");

        // Trap beats MRET and CSR write in the same cycle
        wr(12'h300, 2'b10, 32'h8, 1'b0, "mie_set_pre_trap");
        trap_en          = 1'b1;
        trap_pc          = 32'h10;
        trap_cause       = 32'h2;
        mret_en          = 1'b1;
        bus_if.csr_addr  = 12'h341;
        bus_if.csr_op    = 2'b01;
        bus_if.csr_wdata = 32'h99;
        step();
        trap_en       = 1'b0;
        mret_en       = 1'b0;
        bus_if.csr_op = 2'b00;
        expect_val(4, 32'h10, "trap_mepc");
        rd(12'h342, 32'h2, "trap_mcause");
        rd(12'h300, 32'h0000_1880, "trap_mstatus");

        // Reset during a write and a trap discards both
        bus_if.csr_addr  = 12'h340;
        bus_if.csr_op    = 2'b01;
        bus_if.csr_wdata = 32'h1234;
        trap_en          = 1'b1;
        trap_pc          = 32'h44;
        rst              = 1'b1;
        step();
        rst           = 1'b0;
        trap_en       = 1'b0;
        bus_if.csr_op = 2'b00;
        expect_val(4, 32'h0, "rst_mid_mepc");
        rd(12'h340, 32'h0, "rst_mid_scratch");
        rd(12'h305, 32'h0000_0100, "rst_mid_mtvec");
        rd(12'h300, 32'h0000_1800, "rst_mid_mstatus");

`ifdef CSR_COUNTERS_EN
        wr(12'hB00, 2'b01, 32'hFFFF_FFFF, 1'b0, "mcycle_wr_legal");
        rd(12'hB00, 32'hFFFF_FFFF, "mcycle_written");
        rd(12'hB00, 32'h0, "mcycle_wrap");
        rd(12'hB80, 32'h0, "mcycleh_zero");
        wr(12'hB02, 2'b01, 32'h0, 1'b0, "minstret_wr_legal");
        instret = 1'b1;
        repeat (5) step();
        instret = 1'b0;
        rd(12'hB02, 32'h5, "minstret_five");
        rd(12'hB82, 32'h0, "minstreth_zero");
`else
        wr(12'hB00, 2'b01, 32'hFFFF_FFFF, 1'b1, "ill_mcycle_wr");
        rd(12'hB00, 32'h0, "mcycle_absent_rd");
        wr(12'hB82, 2'b10, 32'h1, 1'b1, "ill_minstreth_set");
        rd(12'hB02, 32'h0, "minstret_absent_rd");
`endif

        for (int i = 0; i < 20; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
